// File: rtl/sdram_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a single SDRAM controller read port.
// Each grant covers one address handshake followed by a fixed-length data burst, with a stall timeout.
module sdram_rd_arbiter #(
   parameter int unsigned AW     = 24,
   parameter int unsigned DW     = 16,
   parameter int unsigned BL     = 8,
   parameter int unsigned TO_CYC = 255
) (
   input  logic          sdram_clk,
   input  logic          rst_n,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_avalid,
   output logic          m0_aready,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   input  logic          m0_rready,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_avalid,
   output logic          m1_aready,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   input  logic          m1_rready,
   output logic [AW-1:0] s_addr,
   output logic          s_avalid,
   input  logic          s_aready,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_rvalid,
   output logic          s_rready,
   output logic [1:0]    grant,
   output logic          err_timeout
);

   localparam int unsigned CNT_W = 5;
   localparam int unsigned STL_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [STL_W-1:0]   stall_q, stall_d;
   logic               last_m1_q, last_m1_d;
   logic               err_q, err_d;
   logic               in_data;
   logic               beat;
   logic               pick_m0;

   // State register; reset leaves last_grant on m1 so m0 wins the first tie.
   always_ff @(posedge sdram_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= 2'b00;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         stall_q    <= '0;
         last_m1_q  <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         stall_q    <= stall_d;
         last_m1_q  <= last_m1_d;
         err_q      <= err_d;
      end
   end

   assign in_data = (state_q == S_DATA);
   assign beat    = s_rvalid & s_rready;

   // Next-state: arbitrate in idle, hold address through the burst, count beats and stalls.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      beat_cnt_d = beat_cnt_q;
      stall_d    = stall_q;
      last_m1_d  = last_m1_q;
      err_d      = 1'b0;
      pick_m0    = m0_avalid & (~m1_avalid | last_m1_q);
      case (state_q)
         S_IDLE: begin
            if (m0_avalid | m1_avalid) begin
               grant_d = pick_m0 ? 2'b01 : 2'b10;
               addr_d  = pick_m0 ? m0_addr : m1_addr;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (s_aready) begin
               state_d    = S_DATA;
               beat_cnt_d = '0;
               stall_d    = '0;
            end
         end
         S_DATA: begin
            if (beat) begin
               stall_d = '0;
               if (beat_cnt_q == CNT_W'(BL - 1)) begin
                  state_d   = S_IDLE;
                  grant_d   = 2'b00;
                  last_m1_d = grant_q[1];
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end else if (stall_q == STL_W'(TO_CYC - 1)) begin
               state_d   = S_IDLE;
               grant_d   = 2'b00;
               last_m1_d = grant_q[1];
               err_d     = 1'b1;
            end else begin
               stall_d = stall_q + STL_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign s_avalid    = (state_q == S_ADDR);
   assign s_addr      = addr_q;
   assign grant       = grant_q;
   assign err_timeout = err_q;

   assign m0_aready = s_avalid & s_aready & grant_q[0];
   assign m1_aready = s_avalid & s_aready & grant_q[1];
   assign s_rready  = in_data & ((grant_q[0] & m0_rready) | (grant_q[1] & m1_rready));
   assign m0_rvalid = in_data & grant_q[0] & s_rvalid;
   assign m1_rvalid = in_data & grant_q[1] & s_rvalid;
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter: single/tied requests, address stall, rready toggling,
// data timeout and mid-burst reset.
module tb_sdram_rd_arbiter;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned BL = 8;
   localparam int unsigned TO_CYC = 255;

   logic          sdram_clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic          m0_avalid, m1_avalid, m0_aready, m1_aready;
   logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
   logic          m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic          s_avalid, s_aready, s_rvalid, s_rready;
   logic [1:0]    grant;
   logic          err_timeout;

   int n_cmp = 0;
   int n_err = 0;

   always #5 sdram_clk = ~sdram_clk;

   sdram_rd_arbiter #(.AW(AW), .DW(DW), .BL(BL), .TO_CYC(TO_CYC)) dut (
      .sdram_clk(sdram_clk), .rst_n(rst_n),
      .m0_addr(m0_addr), .m0_avalid(m0_avalid), .m0_aready(m0_aready),
      .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_addr(m1_addr), .m1_avalid(m1_avalid), .m1_aready(m1_aready),
      .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_addr(s_addr), .s_avalid(s_avalid), .s_aready(s_aready),
      .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .grant(grant), .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sdram_clk);
      #2;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_s_avalid", 32'(s_avalid), 32'h0);
      chk("rst_s_rready", 32'(s_rready), 32'h0);
      chk("rst_m0_aready", 32'(m0_aready), 32'h0);
      chk("rst_m1_aready", 32'(m1_aready), 32'h0);
      chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
      chk("rst_err", 32'(err_timeout), 32'h0);
      chk("rst_s_addr", 32'(s_addr), 32'h0);
   endtask

   // Called in idle with requests already driven; runs one full burst and checks routing.
   task automatic serve(input logic [1:0] eg, input logic [AW-1:0] ea, input bit drop);
      step();
      chk("grant", 32'(grant), 32'(eg));
      chk("s_avalid", 32'(s_avalid), 32'h1);
      chk("s_addr", 32'(s_addr), 32'(ea));
      if (drop) begin
         m0_avalid = 1'b0;
         m1_avalid = 1'b0;
      end
      s_aready = 1'b1;
      #1;
      chk("m0_aready", 32'(m0_aready), 32'(eg[0]));
      chk("m1_aready", 32'(m1_aready), 32'(eg[1]));
      step();
      s_aready = 1'b0;
      m0_rready = 1'b1;
      m1_rready = 1'b1;
      s_rvalid = 1'b1;
      for (int i = 0; i < BL; i++) begin
         s_rdata = DW'(16'h5000 + i);
         #1;
         chk("m0_rvalid", 32'(m0_rvalid), 32'(eg[0]));
         chk("m1_rvalid", 32'(m1_rvalid), 32'(eg[1]));
         chk("rdata", 32'(eg[0] ? m0_rdata : m1_rdata), 32'h5000 + 32'(i));
         chk("s_addr_hold", 32'(s_addr), 32'(ea));
         step();
      end
      s_rvalid = 1'b0;
      chk("end_grant", 32'(grant), 32'h0);
      chk("end_s_avalid", 32'(s_avalid), 32'h0);
   endtask

   initial begin
      int beats;
      int cyc;
      bit m1_bad;
      bit seen;

      rst_n = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_avalid = 0; m1_avalid = 0;
      m0_rready = 0; m1_rready = 0; s_aready = 0; s_rdata = '0; s_rvalid = 0;
      #12;
      chk_reset_outputs();
      rst_n = 1'b1;
      step();

      // Single m0 request: s_avalid not yet up in the request cycle, m0 drops avalid after grant.
      m0_addr = 24'h000100;
      m0_avalid = 1'b1;
      #1;
      chk("req_cycle_s_avalid", 32'(s_avalid), 32'h0);
      serve(2'b01, 24'h000100, 1'b1);
      step();
      chk("idle_after_burst", 32'(grant), 32'h0);

      // m0 alone wins again even though it was granted last; aready held low 10 cycles.
      m0_addr = 24'h00ABCD;
      m0_avalid = 1'b1;
      step();
      m0_avalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("stall_s_avalid", 32'(s_avalid), 32'h1);
         chk("stall_s_addr", 32'(s_addr), 32'h00ABCD);
         chk("stall_m0_aready", 32'(m0_aready), 32'h0);
         step();
      end
      s_aready = 1'b1;
      #1;
      chk("hs_m0_aready", 32'(m0_aready), 32'h1);
      step();
      s_aready = 1'b0;
      chk("single_hs", 32'(s_avalid), 32'h0);

      // Finish that burst with rready toggling 1/0 and s_rvalid always high.
      s_rvalid = 1'b1;
      beats = 0; cyc = 0; m1_bad = 0;
      m1_rready = 1'b1;
      while (grant != 2'b00 && cyc < 40) begin
         m0_rready = (cyc % 2 == 0);
         s_rdata = DW'(16'h7000 + beats);
         #1;
         if (m1_rvalid) m1_bad = 1;
         if (m0_rvalid && m0_rready) beats++;
         step();
         cyc++;
      end
      s_rvalid = 1'b0;
      m0_rready = 1'b1;
      chk("toggle_beats", 32'(beats), 32'(BL));
      chk("toggle_cycles", 32'(cyc), 32'(2 * BL - 1));
      chk("toggle_m1_rvalid", 32'(m1_bad), 32'h0);

      // Reset, then a tie: m0, m1, m0.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step();
      m0_addr = 24'h111111;
      m1_addr = 24'h222222;
      m0_avalid = 1'b1;
      m1_avalid = 1'b1;
      serve(2'b01, 24'h111111, 1'b0);
      serve(2'b10, 24'h222222, 1'b0);
      serve(2'b01, 24'h111111, 1'b1);
      step();

      // m1 burst with s_rvalid stuck low: timeout after TO_CYC stalled cycles.
      m1_addr = 24'h333333;
      m1_avalid = 1'b1;
      step();
      m1_avalid = 1'b0;
      s_aready = 1'b1;
      step();
      s_aready = 1'b0;
      s_rvalid = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 400) begin
         step();
         cyc++;
         if (err_timeout) seen = 1;
      end
      chk("timeout_seen", 32'(seen), 32'h1);
      chk("timeout_cycles", 32'(cyc), 32'(TO_CYC));
      chk("timeout_grant", 32'(grant), 32'h0);
      step();
      chk("timeout_pulse_len", 32'(err_timeout), 32'h0);
      m0_addr = 24'h444444;
      m0_avalid = 1'b1;
      serve(2'b01, 24'h444444, 1'b1);
      step();

      // Mid-burst reset at beat 4, then a fresh m1-only request.
      m0_addr = 24'h555555;
      m0_avalid = 1'b1;
      step();
      m0_avalid = 1'b0;
      s_aready = 1'b1;
      step();
      s_aready = 1'b0;
      s_rvalid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      #1;
      chk("pre_rst_m0_rvalid", 32'(m0_rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      step();
      rst_n = 1'b1;
      s_rvalid = 1'b0;
      step();
      m1_addr = 24'h666666;
      m1_avalid = 1'b1;
      serve(2'b10, 24'h666666, 1'b1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_rd_arbiter.md
SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 24, address width.
REQ-002 The block SHALL have parameter DW, default 16, data width.
REQ-003 The block SHALL have parameter BL, default 8, fixed burst length in beats; legal range 1..16.
REQ-004 The block SHALL have parameter TO_CYC, default 255, data-phase stall timeout in cycles; legal range 1..255.
REQ-005 The block SHALL have port sdram_clk  in  1  sole clock; all logic rises on its posedge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 The block SHALL have ports m0_addr / m1_addr  in  AW  requester read address.
REQ-008 The block SHALL have ports m0_avalid / m1_avalid  in  1  requester address valid.
REQ-009 The block SHALL have ports m0_aready / m1_aready  out  1  requester address accepted.
REQ-010 The block SHALL have ports m0_rdata / m1_rdata  out  DW  read data, both driven from s_rdata.
REQ-011 The block SHALL have ports m0_rvalid / m1_rvalid  out  1  read beat valid.
REQ-012 The block SHALL have ports m0_rready / m1_rready  in  1  requester beat ready.
REQ-013 The block SHALL have port s_addr  out  AW  address to SDRAM controller read port.
REQ-014 The block SHALL have port s_avalid  out  1  address valid to controller.
REQ-015 The block SHALL have port s_aready  in  1  controller address ready.
REQ-016 The block SHALL have port s_rdata  in  DW  controller read data.
REQ-017 The block SHALL have port s_rvalid  in  1  controller beat valid.
REQ-018 The block SHALL have port s_rready  out  1  ready to controller.
REQ-019 The block SHALL have port grant  out  2  one-hot current owner; 2'b00 when idle.
REQ-020 The block SHALL have port err_timeout  out  1  one-cycle pulse on data-phase abort.

Function
REQ-021 The FSM SHALL have states S_IDLE, S_ADDR and S_DATA.
REQ-022 In S_IDLE with any mX_avalid=1, the FSM SHALL latch the winner's address into s_addr, set grant, and move to S_ADDR on the next edge; s_avalid rises 1 cycle after the request.
REQ-023 With both requesting in S_IDLE, arbitration SHALL be round-robin: the requester not granted last wins; last_grant resets to m1, so m0 wins the first tie.
REQ-024 With one requester only, that requester SHALL win regardless of last_grant.
REQ-025 s_avalid SHALL be (state==S_ADDR); s_addr SHALL hold stable from S_ADDR entry through S_DATA exit.
REQ-026 mX_aready SHALL be s_avalid & s_aready & grant[X], combinational; the ungranted aready SHALL stay 0.
REQ-027 On the s_avalid & s_aready handshake, the FSM SHALL move to S_DATA and clear beat_cnt and the stall counter.
REQ-028 In S_DATA, s_rready SHALL equal the granted mX_rready, and the granted mX_rvalid SHALL equal s_rvalid.
REQ-029 Both mX_rvalid outputs SHALL be 0 outside S_DATA; the ungranted one SHALL be 0 always.
REQ-030 s_rready SHALL be 0 outside S_DATA; s_rvalid there is ignored.
REQ-031 Each s_rvalid & s_rready beat SHALL increment beat_cnt (5 bits).
REQ-032 The beat with beat_cnt==BL-1 SHALL return the FSM to S_IDLE, clear grant, and set last_grant to the finishing owner.
REQ-033 After a burst, S_IDLE SHALL last at least one cycle, with no grant on the last-beat edge.
REQ-034 Requests arriving during S_ADDR/S_DATA SHALL wait and are not lost while avalid is held.
REQ-035 In S_DATA, the stall counter SHALL increment on every cycle without a beat and clear on every beat.
REQ-036 When the stall counter reaches TO_CYC, the FSM SHALL go to S_IDLE, clear grant, update last_grant, and pulse err_timeout for one cycle.
REQ-037 Deassertion of avalid by the granted requester after the grant SHALL not abort the burst.

Reset
REQ-038 Asserting rst_n=0 SHALL immediately force: state S_IDLE, grant 0, s_avalid 0, s_rready 0, mX_aready 0, mX_rvalid 0, err_timeout 0, s_addr 0, beat_cnt 0, stall counter 0, last_grant m1.
REQ-039 Reset mid-burst SHALL discard the burst; after release, arbitration SHALL restart as from power-up.

Verification
REQ-040 m0 only, m0_addr=24'h000100 -> s_avalid 1 cycle later with s_addr=24'h000100; after 8 beats grant=00 and m0 receives 8 beats in order.
REQ-041 m0 and m1 requesting in the same cycle after reset -> m0 served first, then m1, then m0; grant alternates 01,10,01.
REQ-042 s_aready held low for 10 cycles -> s_avalid and s_addr stable, m0_aready=0 throughout, then a single handshake.
REQ-043 Granted rready toggling 1/0 -> exactly BL beats counted, m1_rvalid=0 throughout an m0 burst.
REQ-044 s_rvalid stuck low for 255 cycles in S_DATA -> err_timeout pulses once, grant=00, the next request is served.
REQ-045 rst_n pulsed low at beat 4 -> all outputs at reset values asynchronously; a fresh m1-only request afterwards is granted normally.
